// File: rtl/motor_arm_ctrl.sv
// motor_arm_ctrl: arming, spin-up and failsafe sequencer gating four motor commands
module motor_arm_ctrl #(
  parameter int TICK_DIV       = 50000,
  parameter int ARM_HOLD_MS    = 1000,
  parameter int DISARM_HOLD_MS = 1000,
  parameter int SPINUP_MS      = 500,
  parameter int FAILSAFE_MS    = 100,
  parameter int FS_HOLD_MS     = 3000,
  parameter int STICK_LOW      = 50,
  parameter int STICK_HIGH     = 950,
  parameter int IDLE_VAL       = 50,
  parameter int MOTOR_MAX      = 999,
  parameter int FS_VAL         = 400
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        frame_valid,
  input  logic [9:0]  thr,
  input  logic [9:0]  yaw,
  input  logic [47:0] motor_in,
  output logic [47:0] motor_out,
  output logic        armed,
  output logic        failsafe,
  output logic        pid_rst,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_ARMING    = 3'd1,
    S_SPINUP    = 3'd2,
    S_ARMED     = 3'd3,
    S_DISARMING = 3'd4,
    S_FAILSAFE  = 3'd5
  } state_t;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] P_TLAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]  P_LO   = 10'(STICK_LOW);
  localparam logic [9:0]  P_HI   = 10'(STICK_HIGH);
  localparam logic [11:0] P_IDLE = 12'(IDLE_VAL);
  localparam logic [11:0] P_MAX  = 12'(MOTOR_MAX);
  localparam logic [11:0] P_FS   = 12'(FS_VAL);
  localparam logic [15:0] P_WD   = 16'(FAILSAFE_MS);
  localparam logic [16:0] P_ARM  = 17'(ARM_HOLD_MS);
  localparam logic [16:0] P_DIS  = 17'(DISARM_HOLD_MS);
  localparam logic [16:0] P_SPIN = 17'(SPINUP_MS);
  localparam logic [16:0] P_FSH  = 17'(FS_HOLD_MS);
  logic [TW-1:0] r_tick_cnt;
  logic [9:0]    r_thr, r_yaw;
  logic [15:0]   r_wd, r_ms;
  logic          r_seen;
  state_t        r_state, w_nx;
  logic          w_tick, w_link_ok, w_arm_g, w_dis_g;
  logic [16:0]   w_ms_nx;
  logic [47:0]   w_clamp, w_motor_nx;
  assign w_tick    = r_tick_cnt == P_TLAST;
  assign w_link_ok = r_seen && r_wd < P_WD;
  assign w_arm_g   = r_thr < P_LO && r_yaw > P_HI;
  assign w_dis_g   = r_thr < P_LO && r_yaw < P_LO;
  // Hold intervals complete on the tick that would bring the counter to N
  assign w_ms_nx   = {1'b0, r_ms} + {16'd0, w_tick};
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [11:0] w_m;
    assign w_m = motor_in[12*i +: 12];
    assign w_clamp[12*i +: 12] = w_m > P_MAX ? P_MAX : w_m < P_IDLE ? P_IDLE : w_m;
  end
  always_comb begin
    w_nx = S_DISARMED;
    case (r_state)
      S_DISARMED:  w_nx = (w_link_ok && w_arm_g) ? S_ARMING : S_DISARMED;
      S_ARMING:    w_nx = (!w_link_ok || !w_arm_g) ? S_DISARMED : w_ms_nx >= P_ARM ? S_SPINUP : S_ARMING;
      S_SPINUP:    w_nx = !w_link_ok ? S_DISARMED : w_ms_nx >= P_SPIN ? S_ARMED : S_SPINUP;
      S_ARMED:     w_nx = !w_link_ok ? S_FAILSAFE : w_dis_g ? S_DISARMING : S_ARMED;
      S_DISARMING: w_nx = !w_link_ok ? S_FAILSAFE : !w_dis_g ? S_ARMED :
                          w_ms_nx >= P_DIS ? S_DISARMED : S_DISARMING;
      S_FAILSAFE:  w_nx = w_ms_nx >= P_FSH ? S_DISARMED : S_FAILSAFE;
      default:     w_nx = S_DISARMED;
    endcase
  end
  // Outputs are derived from the next state so they switch together with it
  assign w_motor_nx = (w_nx == S_ARMED || w_nx == S_DISARMING) ? w_clamp :
                      w_nx == S_SPINUP   ? {4{P_IDLE}} :
                      w_nx == S_FAILSAFE ? {4{P_FS}} : '0;
  always_ff @(posedge clk) begin
    if (RST) begin
      r_tick_cnt <= '0;
      r_thr      <= 10'd500;
      r_yaw      <= 10'd500;
      r_wd       <= P_WD;
      r_seen     <= 1'b0;
      r_ms       <= '0;
      r_state    <= S_DISARMED;
      motor_out  <= '0;
      armed      <= 1'b0;
      failsafe   <= 1'b0;
      pid_rst    <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_thr      <= frame_valid ? thr : r_thr;
      r_yaw      <= frame_valid ? yaw : r_yaw;
      r_wd       <= frame_valid ? '0 : (w_tick && r_wd < P_WD) ? r_wd + 16'd1 : r_wd;
      r_seen     <= r_seen || frame_valid;
      r_ms       <= w_nx != r_state ? '0 : (w_tick && r_ms != '1) ? r_ms + 16'd1 : r_ms;
      r_state    <= w_nx;
      motor_out  <= w_motor_nx;
      armed      <= w_nx == S_SPINUP || w_nx == S_ARMED || w_nx == S_DISARMING;
      failsafe   <= w_nx == S_FAILSAFE;
      pid_rst    <= !(w_nx == S_ARMED || w_nx == S_DISARMING);
    end
  end
  assign state = r_state;
endmodule

// File: tb/tb_motor_arm_ctrl.sv
// tb_motor_arm_ctrl: scoreboard bench for the arming/failsafe sequencer
module tb_motor_arm_ctrl;
  localparam logic [47:0] M_IN  = {12'd2000, 12'd10, 12'd700, 12'd50};
  localparam logic [47:0] M_EXP = {12'd999, 12'd50, 12'd700, 12'd50};
  localparam logic [47:0] IDLE4 = {4{12'd50}};
  localparam logic [47:0] FS4   = {4{12'd400}};
  logic        clk = 1'b0, RST = 1'b1, frame_valid = 1'b0;
  logic [9:0]  thr = 10'd500, yaw = 10'd500;
  logic [47:0] motor_in = '0, motor_out;
  logic        armed, failsafe, pid_rst;
  logic [2:0]  state;
  int          checks = 0, failures = 0, cyc = 0, fcnt = 0, last_f = 0;
  bit          frames_on = 1'b0;
  logic [47:0] sb_q[$];
  always #5 clk = ~clk;
  motor_arm_ctrl #(
    .TICK_DIV(10), .ARM_HOLD_MS(5), .DISARM_HOLD_MS(5), .SPINUP_MS(3),
    .FAILSAFE_MS(4), .FS_HOLD_MS(6)
  ) dut (
    .clk(clk), .RST(RST), .frame_valid(frame_valid), .thr(thr), .yaw(yaw),
    .motor_in(motor_in), .motor_out(motor_out), .armed(armed),
    .failsafe(failsafe), .pid_rst(pid_rst), .state(state)
  );
  function automatic logic [47:0] clamp_all(input logic [47:0] v);
    logic [47:0] r;
    logic [11:0] m;
    for (int i = 0; i < 4; i++) begin
      m = v[12*i +: 12];
      r[12*i +: 12] = m > 12'd999 ? 12'd999 : m < 12'd50 ? 12'd50 : m;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (frames_on) begin
      fcnt = fcnt == 19 ? 0 : fcnt + 1;
      frame_valid = fcnt == 0;
      if (frame_valid) last_f = cyc;
    end else frame_valid = 1'b0;
  endtask
  task automatic wait_st(input string tag, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, state, s);
  endtask
  task automatic hold(input logic [2:0] s, input logic [47:0] m, input int budget,
                      output int len, output int bad);
    len = 0;
    bad = 0;
    while (state === s && len < budget) begin
      if (motor_out !== m) bad++;
      len++;
      step();
    end
  endtask
  task automatic arm_up();
    int len, bad;
    thr = 10'd0;
    yaw = 10'd999;
    if (!frames_on) begin
      frames_on = 1'b1;
      fcnt = 19;
    end
    wait_st("arm_enter", 3'd1, 60);
    hold(3'd1, '0, 60, len, bad);
    chk("arming_len", len >= 40 && len <= 50, 1);
    chk("arming_motor", bad, 0);
    chk("spinup_enter", state, 3'd2);
    chk("spinup_armed", armed, 1);
    hold(3'd2, IDLE4, 40, len, bad);
    chk("spinup_len", len >= 21 && len <= 30, 1);
    chk("spinup_motor", bad, 0);
    chk("armed_enter", state, 3'd3);
    chk("armed_pid", pid_rst, 0);
    chk("armed_motor", motor_out, M_EXP);
  endtask
  initial begin
    int len, bad, len2, bad2;
    logic [47:0] v;
    repeat (2) step();
    chk("rst_state", state, 0);
    chk("rst_motor", motor_out, 0);
    chk("rst_armed", armed, 0);
    chk("rst_failsafe", failsafe, 0);
    chk("rst_pid", pid_rst, 1);
    RST = 1'b0;
    thr = 10'd0;
    yaw = 10'd999;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (state !== 3'd0 || motor_out !== '0) bad++;
    end
    chk("boot_noarm", bad, 0);
    motor_in = M_IN;
    arm_up();
    for (int i = 0; i < 10; i++) begin
      v = i == 0 ? {12'd1500, 12'd20, 12'd500, 12'd999} :
          {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
      motor_in = v;
      sb_q.push_back(clamp_all(v));
      step();
      chk("clamp", motor_out, sb_q.pop_front());
    end
    motor_in = M_IN;
    step();
    yaw = 10'd0;
    wait_st("dis_enter", 3'd4, 40);
    chk("dis_pid", pid_rst, 0);
    hold(3'd4, M_EXP, 10, len, bad);
    yaw = 10'd500;
    hold(3'd4, M_EXP, 40, len2, bad2);
    chk("dis_release", state, 3'd3);
    chk("dis_glitch", bad + bad2, 0);
    chk("dis_release_motor", motor_out, M_EXP);
    yaw = 10'd0;
    wait_st("dis_enter2", 3'd4, 40);
    hold(3'd4, M_EXP, 70, len, bad);
    chk("dis_len", len >= 40 && len <= 50, 1);
    chk("dis_motor", bad, 0);
    chk("dis_done", state, 0);
    chk("dis_done_motor", motor_out, 0);
    chk("dis_done_pid", pid_rst, 1);
    chk("dis_done_armed", armed, 0);
    yaw = 10'd999;
    wait_st("abort_enter", 3'd1, 40);
    hold(3'd1, '0, 10, len, bad);
    yaw = 10'd500;
    hold(3'd1, '0, 50, len2, bad2);
    chk("abort_state", state, 0);
    chk("abort_motor", bad + bad2, 0);
    chk("abort_out", motor_out, 0);
    arm_up();
    frames_on = 1'b0;
    wait_st("fs_enter", 3'd5, 60);
    chk("fs_latency", cyc - last_f >= 31 && cyc - last_f <= 42, 1);
    chk("fs_flag", failsafe, 1);
    chk("fs_motor", motor_out, FS4);
    chk("fs_armed", armed, 0);
    chk("fs_pid", pid_rst, 1);
    yaw = 10'd500;
    frames_on = 1'b1;
    fcnt = 19;
    hold(3'd5, FS4, 80, len, bad);
    chk("fs_len", len >= 50 && len <= 60, 1);
    chk("fs_hold_motor", bad, 0);
    chk("fs_done", state, 0);
    chk("fs_done_motor", motor_out, 0);
    chk("fs_done_flag", failsafe, 0);
    arm_up();
    RST = 1'b1;
    frames_on = 1'b0;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_motor", motor_out, 0);
    chk("midrst_pid", pid_rst, 1);
    chk("midrst_armed", armed, 0);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state !== 3'd0) bad++;
    end
    chk("midrst_noarm", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_arm_ctrl.md
# motor_arm_ctrl

Arming, spin-up and failsafe sequencer that sits between the motor mixer and `pwm_encoder`. It watches PPM frame arrival from `ppm_decoder` and the throttle/yaw stick positions, and gates the four mixed motor commands accordingly:
- zero while disarmed;
- idle during spin-up;
- clamped mixer values while armed;
- a fixed descent value on link loss.

It also holds the PID controllers in reset whenever the craft is not flying.

## Interface
Parameters:
- `TICK_DIV`, 50000: clk cycles per 1 ms tick.
- `ARM_HOLD_MS`, 1000: ms the arm gesture must be held.
- `DISARM_HOLD_MS`, 1000: ms the disarm gesture must be held.
- `SPINUP_MS`, 500: ms of idle output before ARMED.
- `FAILSAFE_MS`, 100: ms without a frame that declares link loss.
- `FS_HOLD_MS`, 3000: ms of descent output before forced disarm.
- `STICK_LOW`, 50: stick value strictly below this counts as low.
- `STICK_HIGH`, 950: stick value strictly above this counts as high.
- `IDLE_VAL`, 50: minimum motor command while spinning.
- `MOTOR_MAX`, 999: maximum motor command (0x3E7).
- `FS_VAL`, 400: motor command during FAILSAFE.

Ports:
- `clk`, in, 1: system clock.
- `RST`, in, 1: synchronous reset, active-high. One clock, synchronous active-high reset.
- `frame_valid`, in, 1: single-cycle pulse per completed PPM frame.
- `thr`, in, 10: throttle channel (0..999), valid with `frame_valid`.
- `yaw`, in, 10: yaw channel (0..999), valid with `frame_valid`.
- `motor_in`, in, 48: packed mixer commands {m3,m2,m1,m0}, 12-bit unsigned each.
- `motor_out`, out, 48: packed gated commands to `pwm_encoder`, same packing.
- `armed`, out, 1: high in SPINUP, ARMED, DISARMING.
- `failsafe`, out, 1: high in FAILSAFE.
- `pid_rst`, out, 1: high in every state except ARMED and DISARMING.
- `state`, out, 3: current state encoding.

## Operation
Millisecond tick:
- `tick_cnt` counts 0..`TICK_DIV`-1 and wraps.
- `tick` is a 1-cycle pulse at wrap.
- All ms counters are 16-bit and advance only on `tick`.

Stick latch:
- `thr` and `yaw` are registered on `frame_valid`.
- All gestures use the latched values.
- Arm gesture: thr<`STICK_LOW` and yaw>`STICK_HIGH`.
- Disarm gesture: thr<`STICK_LOW` and yaw<`STICK_LOW`.

Link watchdog:
- `wd` is cleared on `frame_valid`, otherwise increments on `tick`, saturating at `FAILSAFE_MS`.
- `seen` is set by the first `frame_valid` after reset.
- `link_ok` = `seen` and `wd` < `FAILSAFE_MS`.
- If `frame_valid` and `tick` occur in the same cycle, `frame_valid` wins and `wd` is 0.

States and transitions (link-loss checks take priority over gesture checks):
- DISARMED (0): output 0.
  - link_ok and arm gesture -> ARMING; hold counter cleared.
- ARMING (1): output 0.
  - Link lost or gesture released -> DISARMED.
  - Hold counter reaches `ARM_HOLD_MS` -> SPINUP.
- SPINUP (2): all motors `IDLE_VAL`.
  - Link lost -> DISARMED.
  - Counter reaches `SPINUP_MS` -> ARMED.
- ARMED (3): each motor = clamp(m_i, `IDLE_VAL`, `MOTOR_MAX`).
  - Link lost -> FAILSAFE.
  - Disarm gesture -> DISARMING; counter cleared.
- DISARMING (4): output as ARMED.
  - Link lost -> FAILSAFE.
  - Gesture released -> ARMED.
  - Counter reaches `DISARM_HOLD_MS` -> DISARMED.
- FAILSAFE (5): all motors `FS_VAL`.
  - Counter reaches `FS_HOLD_MS` -> DISARMED.
  - Link recovery does not change state. The operator must re-arm from DISARMED.
- Codes 6 and 7 are illegal and recover to DISARMED on the next cycle.

Other rules:
- Every state entry clears the shared ms counter.
- Clamp is an unsigned 12-bit compare per lane: values >`MOTOR_MAX` become `MOTOR_MAX`, values <`IDLE_VAL` become `IDLE_VAL`.

## Timing
- All outputs are registered.
- Values after RST: `state`=DISARMED, `motor_out`=0, `armed`=0, `failsafe`=0, `pid_rst`=1, `seen`=0, `wd`=`FAILSAFE_MS`, `tick_cnt`=0, latched sticks=500.
- Latencies:
  - `motor_out` follows `motor_in` with 1-cycle latency in ARMED/DISARMING.
  - State change is visible 1 cycle after the deciding condition.
  - Outputs for the new state take effect in that same cycle.
- Hold intervals are measured from state entry. Actual duration is N-1 to N ms because the tick phase is free-running.
- RST in any state, including mid-flight, forces the reset values on the next edge. Motors go to 0, not `FS_VAL`.

## Test plan
Bench parameters: `TICK_DIV`=10, `ARM_HOLD_MS`=5, `SPINUP_MS`=3, `DISARM_HOLD_MS`=5, `FAILSAFE_MS`=4, `FS_HOLD_MS`=6, frames every 20 cycles.
- Arm sequence: frames with thr=0, yaw=999 -> DISARMED -> ARMING -> SPINUP within 50 cycles; `motor_out`=4x50 for 21-30 cycles; then ARMED, `pid_rst`=0.
- Clamp: ARMED, `motor_in`={1500,20,500,999} -> `motor_out`={999,50,500,999} one cycle later.
- Aborted arm: release yaw to 500 after 2 ms in ARMING -> DISARMED; `motor_out` stays 0 throughout.
- Link loss: ARMED, stop frames -> FAILSAFE after 31-40 cycles; `motor_out`=4x400, `failsafe`=1. Resume frames -> stays FAILSAFE. After 6 ms -> DISARMED, outputs 0.
- Disarm: ARMED, thr=0, yaw=0 held -> DISARMED after 5 ms. Releasing at 3 ms returns to ARMED with no output glitch.
- Reset and boot: RST for 1 cycle while ARMED -> next cycle `state`=0, `motor_out`=0, `pid_rst`=1. No arming is possible before the first `frame_valid`.
